// File: rtl/issue_drain_ctrl_if.sv
// Issue/drain handshake bundle between the wavefront issue logic (master)
// and the drain controller (slave).
interface issue_drain_ctrl_if #(
   parameter int WFID_WIDTH = 6
);
   logic                  issue_req;
   logic                  drain_req;
   logic [WFID_WIDTH-1:0] drain_req_wfid;
   logic                  issue_grant;
   logic                  drain_done;
   logic [WFID_WIDTH-1:0] drain_done_wfid;
   logic                  drain_busy;

   // Issue logic: raises requests, consumes grants and drain status.
   modport master (
      output issue_req,
      output drain_req,
      output drain_req_wfid,
      input  issue_grant,
      input  drain_done,
      input  drain_done_wfid,
      input  drain_busy
   );

   // Drain controller: consumes requests, produces grants and drain status.
   modport slave (
      input  issue_req,
      input  drain_req,
      input  drain_req_wfid,
      output issue_grant,
      output drain_done,
      output drain_done_wfid,
      output drain_busy
   );
endinterface

// File: rtl/issue_drain_ctrl.sv
// issue_drain_ctrl: gates instruction issue against the inflight counter and
// sequences full pipeline drains (barrier / endpgm / full waitcnt).
// A draining instruction moves the FSM IDLE -> DRAIN -> DONE -> IDLE; DONE is
// reached after the inflight counter has reported empty for SETTLE_CYCLES
// consecutive cycles, and drain_done pulses for exactly that one cycle.
// Optional feature: define ISSUE_DRAIN_PERF_EN to build the saturating
// issue-stall counter behind stall_cycles; otherwise the port reads zero.
module issue_drain_ctrl #(
   parameter int WFID_WIDTH    = 6,
   parameter int SETTLE_CYCLES = 2   // legal range 1..15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                no_inflight_instr_flag,
   input  logic                max_inflight_instr_flag,
   issue_drain_ctrl_if.slave   bus,
   output logic [15:0]         stall_cycles
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Settle count value on which the last required empty cycle is observed.
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_e                state_q,      state_d;
   logic [3:0]            settle_cnt_q, settle_cnt_d;
   logic [WFID_WIDTH-1:0] wfid_q,       wfid_d;

   logic issue_grant_s;
   logic drain_done_s;
   logic drain_busy_s;

   // State, settle counter and latched wavefront ID registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         settle_cnt_q <= 4'd0;
         wfid_q       <= '0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         wfid_q       <= wfid_d;
      end
   end

   // Next-state logic and issue/drain outputs decoded from the current state.
   always_comb begin
      state_d       = state_q;
      settle_cnt_d  = settle_cnt_q;
      wfid_d        = wfid_q;
      issue_grant_s = 1'b0;
      drain_done_s  = 1'b0;
      drain_busy_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Normal issue is throttled only by a full inflight counter.
            issue_grant_s = bus.issue_req & ~bus.drain_req & ~max_inflight_instr_flag;
            // A bare drain_req without issue_req is not a request.
            if (bus.issue_req && bus.drain_req) begin
               state_d      = ST_DRAIN;
               settle_cnt_d = 4'd0;
               wfid_d       = bus.drain_req_wfid;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            drain_busy_s = 1'b1;
            // Any non-empty cycle restarts the settle window.
            if (no_inflight_instr_flag && (settle_cnt_q == SETTLE_LAST)) begin
               state_d = ST_DONE;
            end else if (no_inflight_instr_flag) begin
               settle_cnt_d = settle_cnt_q + 4'd1;
            end else begin
               settle_cnt_d = 4'd0;
            end
         end
         ST_DONE: begin
            // The draining instruction itself issues in the DONE cycle.
            drain_busy_s  = 1'b1;
            drain_done_s  = 1'b1;
            issue_grant_s = bus.issue_req;
            state_d       = ST_IDLE;
         end
         default: begin
            state_d      = ST_IDLE;
            settle_cnt_d = 4'd0;
         end
      endcase
   end

   assign bus.issue_grant     = issue_grant_s;
   assign bus.drain_done      = drain_done_s;
   assign bus.drain_busy      = drain_busy_s;
   assign bus.drain_done_wfid = wfid_q;

`ifdef ISSUE_DRAIN_PERF_EN
   logic [15:0] stall_q, stall_d;

   // Next stall count: one per cycle with a request that was not granted, saturating.
   always_comb begin
      stall_d = stall_q;
      if (bus.issue_req && !issue_grant_s && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end else begin
         stall_d = stall_q;
      end
   end

   // Stall counter register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= 16'd0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_issue_drain_ctrl.sv
// Directed self-checking bench for issue_drain_ctrl (SETTLE_CYCLES = 2).
// Inputs for a cycle are applied 1 time unit after its rising edge; outputs
// are checked on the following falling edge.
module tb_issue_drain_ctrl;

   logic       clk;
   logic       rst;
   logic       no_inflight_instr_flag;
   logic       max_inflight_instr_flag;
   logic [15:0] stall_cycles;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   issue_drain_ctrl_if #(.WFID_WIDTH(6)) bus ();

   issue_drain_ctrl #(
      .WFID_WIDTH    (6),
      .SETTLE_CYCLES (2)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .no_inflight_instr_flag  (no_inflight_instr_flag),
      .max_inflight_instr_flag (max_inflight_instr_flag),
      .bus                     (bus),
      .stall_cycles            (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle and apply the inputs for it.
   task automatic cycle(input logic r, input logic ir, input logic dr,
                        input logic [5:0] wfid, input logic nf, input logic mx);
      @(posedge clk);
      #1;
      rst                     = r;
      bus.issue_req           = ir;
      bus.drain_req           = dr;
      bus.drain_req_wfid      = wfid;
      no_inflight_instr_flag  = nf;
      max_inflight_instr_flag = mx;
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check all drain-status outputs plus grant in one go.
   task automatic check_out(input string tag, input logic g, input logic d,
                            input logic [5:0] w, input logic b);
      check({tag, ".grant"}, {31'd0, bus.issue_grant}, {31'd0, g});
      check({tag, ".done"},  {31'd0, bus.drain_done},  {31'd0, d});
      check({tag, ".wfid"},  {26'd0, bus.drain_done_wfid}, {26'd0, w});
      check({tag, ".busy"},  {31'd0, bus.drain_busy},  {31'd0, b});
   endtask

   initial begin
      rst = 1'b1;
      bus.issue_req = 1'b0;
      bus.drain_req = 1'b0;
      bus.drain_req_wfid = 6'h00;
      no_inflight_instr_flag = 1'b0;
      max_inflight_instr_flag = 1'b0;

      // Reset state
      cycle(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      check_out("rst", 1'b0, 1'b0, 6'h00, 1'b0);
      check("rst.stall", {16'd0, stall_cycles}, 32'd0);

      // Plain issue throttled by the max flag
      cycle(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
      check_out("iss0", 1'b1, 1'b0, 6'h00, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1);
      check_out("iss1", 1'b0, 1'b0, 6'h00, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
      check_out("iss2", 1'b1, 1'b0, 6'h00, 1'b0);
      // drain_req without issue_req is ignored
      cycle(1'b0, 1'b0, 1'b1, 6'h3C, 1'b1, 1'b0);
      check_out("bare_dr", 1'b0, 1'b0, 6'h00, 1'b0);

      // Minimum-latency drain, flag high throughout; new requests in DRAIN ignored
      cycle(1'b0, 1'b1, 1'b1, 6'h2A, 1'b1, 1'b0);
      check_out("min_c0", 1'b0, 1'b0, 6'h00, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 6'h15, 1'b1, 1'b0);
      check_out("min_c1", 1'b0, 1'b0, 6'h2A, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 6'h15, 1'b1, 1'b0);
      check_out("min_c2", 1'b0, 1'b0, 6'h2A, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 6'h15, 1'b1, 1'b0);
      check_out("min_c3", 1'b1, 1'b1, 6'h2A, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 6'h15, 1'b1, 1'b0);
      check_out("min_c4", 1'b0, 1'b0, 6'h2A, 1'b0);

      // Flag drop mid-settle restarts the count: flags 1,0,1,1 from cycle 1
      cycle(1'b0, 1'b1, 1'b1, 6'h11, 1'b0, 1'b0);
      check_out("rs_c0", 1'b0, 1'b0, 6'h2A, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("rs_c1", 1'b0, 1'b0, 6'h11, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      check_out("rs_c2", 1'b0, 1'b0, 6'h11, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("rs_c3", 1'b0, 1'b0, 6'h11, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("rs_c4", 1'b0, 1'b0, 6'h11, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("rs_c5", 1'b0, 1'b1, 6'h11, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("rs_c6", 1'b0, 1'b0, 6'h11, 1'b0);

      // Back-to-back drains, second accepted in the cycle after DONE
      cycle(1'b0, 1'b1, 1'b1, 6'h01, 1'b1, 1'b0);
      check_out("bb_c0", 1'b0, 1'b0, 6'h11, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("bb_c2", 1'b0, 1'b0, 6'h01, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("bb_c3", 1'b1, 1'b1, 6'h01, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 6'h02, 1'b1, 1'b0);
      check_out("bb_c4", 1'b0, 1'b0, 6'h01, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("bb_c6", 1'b0, 1'b0, 6'h02, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("bb_c7", 1'b0, 1'b1, 6'h02, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("bb_c8", 1'b0, 1'b0, 6'h02, 1'b0);

      // Reset in cycle 2 of a drain abandons it
      cycle(1'b0, 1'b1, 1'b1, 6'h33, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      check_out("mr_c1", 1'b0, 1'b0, 6'h33, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("mr_c2", 1'b0, 1'b0, 6'h33, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("mr_c3", 1'b0, 1'b0, 6'h00, 1'b0);
      check("mr_c3.stall", {16'd0, stall_cycles}, 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("mr_c5", 1'b0, 1'b0, 6'h00, 1'b0);
      // Fresh drain after reset
      cycle(1'b0, 1'b1, 1'b1, 6'h05, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      check_out("fr_c3", 1'b0, 1'b1, 6'h05, 1'b1);

      // Stall counter behaviour
      cycle(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1);
      check("st_grant", {31'd0, bus.issue_grant}, 32'd0);
`ifdef ISSUE_DRAIN_PERF_EN
      check("st_small", {16'd0, stall_cycles}, 32'd2);
      for (int i = 0; i < 70000; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1);
      end
      check("st_sat", {16'd0, stall_cycles}, 32'h0000FFFF);
      cycle(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      check("st_clr", {16'd0, stall_cycles}, 32'd0);
`else
      for (int i = 0; i < 200; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1);
      end
      check("st_zero", {16'd0, stall_cycles}, 32'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/issue_drain_ctrl.md
ISSUE_DRAIN_CTRL -- requirements
Module: issue_drain_ctrl

Interface
REQ-001 Parameter WFID_WIDTH, default 6: width of wavefront ID fields.
REQ-002 Parameter SETTLE_CYCLES, default 2: consecutive cycles with no_inflight_instr_flag=1 needed before a drain completes; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 no_inflight_instr_flag  input  1  from inflight counter; 1 = zero instructions in flight.
REQ-006 max_inflight_instr_flag  input  1  from inflight counter; 1 = counter at maximum (15).
REQ-007 issue_req  input  1  issue logic holds a ready instruction this cycle.
REQ-008 drain_req  input  1  qualifies issue_req; the instruction needs a full pipeline drain before issue (barrier, endpgm, full waitcnt).
REQ-009 drain_req_wfid  input  WFID_WIDTH  wavefront ID of the draining instruction; sampled with drain_req.
REQ-010 issue_grant  output  1  instruction may issue this cycle.
REQ-011 drain_done  output  1  single-cycle pulse; pipeline drained for the latched wavefront.
REQ-012 drain_done_wfid  output  WFID_WIDTH  latched wavefront ID; valid when drain_done=1.
REQ-013 drain_busy  output  1  drain in progress (state DRAIN or DONE).
REQ-014 stall_cycles  output  16  issue stall count (see Configuration).

Function
REQ-015 FSM states IDLE, DRAIN, DONE; 2-bit state register; 4-bit settle counter settle_cnt.
REQ-016 IDLE: issue_grant = issue_req & ~drain_req & ~max_inflight_instr_flag, combinational, same cycle.
REQ-017 IDLE with issue_req=1 and drain_req=1: latch drain_req_wfid, clear settle_cnt, go to DRAIN; issue_grant=0 that cycle, even if max flag=0.
REQ-018 drain_req=1 with issue_req=0 is ignored; state stays IDLE.
REQ-019 DRAIN: issue_grant=0; drain_busy=1; if no_inflight_instr_flag=1 and settle_cnt==SETTLE_CYCLES-1 go to DONE; else if flag=1 increment settle_cnt; else clear settle_cnt to 0.
REQ-020 Flag already high at request: drain still passes through DRAIN; drain_done first asserts SETTLE_CYCLES+1 cycles after the request cycle (minimum latency).
REQ-021 Flag dropping mid-settle restarts the count; no upper bound on time spent in DRAIN.
REQ-022 DONE lasts exactly one cycle: drain_done=1, drain_done_wfid=latched ID, drain_busy=1, issue_grant=issue_req; next state IDLE unconditionally.
REQ-023 issue_req/drain_req changes while in DRAIN are ignored; latched wfid is held until the next accepted request.
REQ-024 A new drain request can be accepted in the IDLE cycle directly after DONE (back-to-back drains, no bubble beyond DONE).
REQ-025 drain_done_wfid holds its last latched value outside DONE; drain_done=0 outside DONE.

Reset
REQ-026 rst=1 at a clock edge: state=IDLE, settle_cnt=0, latched wfid=0, stall_cycles=0; rst takes priority over every other input.
REQ-027 After reset: issue_grant follows REQ-016 combinationally; drain_done=0, drain_busy=0, drain_done_wfid=0.
REQ-028 rst asserted mid-drain abandons the drain with no drain_done pulse; a post-reset request starts a fresh drain.

Configuration
REQ-029 Macro ISSUE_DRAIN_PERF_EN defined: stall_cycles increments by 1 each cycle with issue_req=1 and issue_grant=0, saturates at 16'hFFFF, cleared only by rst.
REQ-030 Macro ISSUE_DRAIN_PERF_EN undefined: stall_cycles port present, tied to 16'h0000, no counter logic instantiated; all other behaviour identical.

Verification
REQ-031 SETTLE_CYCLES=2, flag=1 throughout, issue_req=drain_req=1, wfid=6'h2A at cycle 0 -> drain_busy=1 in cycles 1-3, drain_done=1 with wfid 6'h2A in cycle 3 only, issue_grant=1 in cycle 3.
REQ-032 IDLE, issue_req=1, drain_req=0, max flag 0/1/0 over cycles 0-2 -> issue_grant 1/0/1.
REQ-033 Drain with flag pattern 1,0,1,1 from cycle 1 (SETTLE_CYCLES=2) -> drain_done in cycle 5, not earlier.
REQ-034 rst pulse in cycle 2 of a drain -> no drain_done, IDLE in cycle 3, all outputs at reset values.
REQ-035 PERF_EN defined, issue_req=1 with max flag=1 for 70000 cycles -> stall_cycles stops at 16'hFFFF; PERF_EN undefined, same stimulus -> stall_cycles stays 0.
REQ-036 Two drains back-to-back (wfids 6'h01, 6'h02) -> two drain_done pulses, correct IDs, second request accepted in the cycle after the first DONE.
